// File: rtl/glip_uart_pkg.sv
// Shared types and constants for the GLIP UART receive path.
package glip_uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_rx_state_e;

endpackage

// File: rtl/glip_sync2.sv
// Two-flop synchroniser for a single asynchronous input (rx, cts_n, ...).
// RESET_VAL selects the value both flops take in reset, normally the line idle level.
module glip_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next-state values: a plain two-stage shift.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchroniser flops, both forced to the idle level in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/glip_uart_rx_sampler.sv
// 8N1 UART receive front end: synchronises rx, finds the start bit, samples
// the data bits LSB-first at bit centre and checks the stop bit.
// Optional macro GLIP_UART_RX_MAJORITY_EN: bit decisions use a 3-sample
// majority vote of the synchronised line instead of a single sample.
module glip_uart_rx_sampler
   import glip_uart_pkg::*;
#(
   parameter  int DIVISOR   = 16,
   localparam int CNT_WIDTH = $clog2(DIVISOR)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       enable,
   output logic       error,
   output logic       busy
);

   localparam int IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(DIVISOR / 2 - 1);
   localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(DIVISOR - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

   logic rx_s;
   logic sample;

   uart_rx_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      enable_q, enable_d;
   logic                      error_q, error_d;

   glip_sync2 #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

`ifdef GLIP_UART_RX_MAJORITY_EN
   // Together with rx_s itself, the two previous rx_s values form the
   // 3-sample window; a single-cycle spike can never win the vote.
   logic [1:0] hist_q, hist_d;

   // Shift the current synchronised sample into the history.
   always_comb begin
      hist_d = {hist_q[0], rx_s};
   end

   // History flops start at the idle level so the first vote is not skewed.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign sample = rx_s;
`endif

   // Receive FSM and bit timing: next state, counters, shift register and strobes.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      enable_d = 1'b0;
      error_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         // Re-check the start bit half a bit period in; a high line there was a glitch.
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!sample) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end

         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shreg_d = {sample, shreg_q[UART_DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end

         // Leaving at stop-bit centre leaves half a bit to catch a back-to-back start edge.
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (sample) begin
                  data_d   = shreg_q;
                  enable_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  error_d = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end

         // A held-low (break) line must not be decoded as a stream of zero frames.
         WAIT_HIGH: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any partial byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         enable_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         enable_q <= enable_d;
         error_q  <= error_d;
      end
   end

   assign data   = data_q;
   assign enable = enable_q;
   assign error  = error_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_glip_uart_rx_sampler.sv
// Scoreboard bench for glip_uart_rx_sampler: frames are serialised from bytes,
// the expected strobe is queued at frame start and a monitor checks each strobe.
module tb_glip_uart_rx_sampler;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       enable;
   logic       error;
   logic       busy;

   glip_uart_rx_sampler #(
      .DIVISOR (DIV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .data   (data),
      .enable (enable),
      .error  (error),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] byte_v;
      int         fall;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] hold_data = 8'h00;

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      int   lat;
      if (!rst && (enable || error)) begin
         checks++;
         if (enable && error) begin
            errors++;
            $display("FAIL both_strobes enable=%0d error=%0d required only one", enable, error);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe enable=%0d error=%0d data=%h required none", enable, error, data);
         end else begin
            e = sb.pop_front();
            if (e.is_err != error) begin
               errors++;
               $display("FAIL strobe_kind error=%0d enable=%0d required error=%0d", error, enable, e.is_err);
            end else if (enable) begin
               if (data != e.byte_v) begin
                  errors++;
                  $display("FAIL rx_data got=%h required=%h", data, e.byte_v);
               end
               hold_data = e.byte_v;
               lat = cyc - e.fall;
               checks++;
               if (lat < DIV/2 + 9*DIV - 1 + 2 || lat > DIV/2 + 9*DIV + 1 + 2) begin
                  errors++;
                  $display("FAIL latency got=%0d required=%0d+-1", lat, 2 + DIV/2 + 9*DIV);
               end
            end else begin
               checks++;
               if (data != hold_data) begin
                  errors++;
                  $display("FAIL data_hold_on_error got=%h required=%h", data, hold_data);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      tick(n * DIV);
   endtask

   // Serialise one 8N1 frame; spike7 pulls the line low for the single cycle
   // that lands on the bit-7 centre decision.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit spike7,
                             input logic [7:0] expv);
      exp_t e;
      e.is_err = !stop_ok;
      e.byte_v = expv;
      e.fall   = cyc;
      sb.push_back(e);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         if (spike7 && i == 7) begin
            rx = b[i];
            tick(DIV/2);
            rx = 1'b0;
            tick(1);
            rx = b[i];
            tick(DIV/2 - 1);
         end else begin
            rx = b[i];
            tick(DIV);
         end
      end
      rx = stop_ok;
      tick(DIV);
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog timeout queue=%0d", sb.size());
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] b;
      logic [7:0] spike_exp;
      int         n;

      rst = 1'b1;
      rx  = 1'b1;
      tick(3);
      check("reset_data", data, 8'h00);
      check("reset_enable", {7'd0, enable}, 8'h00);
      check("reset_error", {7'd0, error}, 8'h00);
      check("reset_busy", {7'd0, busy}, 8'h00);
      rst = 1'b0;
      idle_bits(2);

      // Single frame with idle line around it.
      send_frame(8'hA5, 1'b1, 1'b0, 8'hA5);
      idle_bits(2);

      // Back-to-back frames, then one after a single idle bit.
      send_frame(8'h00, 1'b1, 1'b0, 8'h00);
      send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
      idle_bits(1);
      send_frame(8'h3C, 1'b1, 1'b0, 8'h3C);
      idle_bits(2);

      // Short low glitch: start rejected, no strobe.
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      check("glitch_busy_seen", {7'd0, busy}, 8'h01);
      n = 0;
      while (busy && n <= DIV/2 + 1) begin
         tick(1);
         n++;
      end
      check("glitch_busy_drop", {7'd0, busy}, 8'h00);
      idle_bits(2);

      // Framing error followed by a held-low line, then a good frame.
      send_frame(8'h55, 1'b0, 1'b0, 8'h00);
      tick(20);
      check("break_busy_mid", {7'd0, busy}, 8'h01);
      tick(20);
      check("break_busy_end", {7'd0, busy}, 8'h01);
      rx = 1'b1;
      tick(4);
      check("break_release_busy", {7'd0, busy}, 8'h00);
      idle_bits(1);
      send_frame(8'h81, 1'b1, 1'b0, 8'h81);
      idle_bits(2);

      // Reset in the middle of data bit 4.
      b  = 8'hC3;
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         tick(DIV);
      end
      rx = b[4];
      tick(DIV/2);
      rst = 1'b1;
      rx  = 1'b1;
      tick(1);
      check("midrst_data", data, 8'h00);
      check("midrst_enable", {7'd0, enable}, 8'h00);
      check("midrst_busy", {7'd0, busy}, 8'h00);
      rst = 1'b0;
      hold_data = 8'h00;
      idle_bits(2);
      send_frame(8'h12, 1'b1, 1'b0, 8'h12);
      idle_bits(2);

      // Single-cycle spike on the bit-7 decision.
`ifdef GLIP_UART_RX_MAJORITY_EN
      spike_exp = 8'hF0;
`else
      spike_exp = 8'h70;
`endif
      send_frame(8'hF0, 1'b1, 1'b1, spike_exp);
      idle_bits(2);

      // Random frames with random gaps, occasionally a framing error.
      for (int k = 0; k < 25; k++) begin
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) begin
            send_frame(b, 1'b0, 1'b0, 8'h00);
            tick($urandom_range(0, 30));
            idle_bits(1);
         end else begin
            send_frame(b, 1'b1, 1'b0, b);
            rx = 1'b1;
            tick($urandom_range(0, 20));
         end
      end
      idle_bits(2);

      n = 0;
      while (sb.size() != 0 && n < 400) begin
         tick(1);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain outstanding=%0d required=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
